// File: rtl/fp_exc_pkg.sv
// Shared types and constants for the floating-point exception unit:
// operand class record, sticky bit positions and the all-ones exponent.
package fp_exc_pkg;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
  } fp_class_t;

  localparam int STK_INV  = 3;
  localparam int STK_OVF  = 2;
  localparam int STK_UNF  = 1;
  localparam int STK_ZERO = 0;

  function automatic logic [31:0] exp_max(input int exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero / subnormal / infinity / NaN.
// With DAZ set, subnormals are reported as zero and never as sub.
module fp_classify
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DAZ   = 0
) (
  input  logic [EXP_W-1:0] exp_in,
  input  logic [MAN_W-1:0] man_in,
  output fp_class_t        cls
);

  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_max(EXP_W));

  logic exp_zero;
  logic exp_all;
  logic man_zero;

  assign exp_zero = (exp_in == '0);
  assign exp_all  = (exp_in == EXP_MAX);
  assign man_zero = (man_in == '0);

  always_comb begin
    cls.zero = exp_zero & (man_zero | (DAZ != 0));
    cls.sub  = exp_zero & !man_zero & (DAZ == 0);
    cls.inf  = exp_all & man_zero;
    cls.nan  = exp_all & !man_zero;
  end

endmodule

// File: rtl/fp_exc_unit.sv
// Exception flag unit: classifies operands at issue, delays only the class
// bits, and merges them with the datapath result arriving LAT cycles later.
module fp_exc_unit
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT   = 7,
  parameter int DAZ   = 0,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [EXP_W-1:0] Ex,
  input  logic [EXP_W-1:0] Ey,
  input  logic [MAN_W-1:0] Mx,
  input  logic [MAN_W-1:0] My,
  input  logic [EXP_W-1:0] Ez,
  input  logic [MAN_W-1:0] Mz,
  input  logic             ovf_case,
  input  logic             unf_case,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic             invalid_flag,
  output logic             overflow_flag,
  output logic             underflow_flag,
  output logic             zero_flag,
  output logic             nan_flag,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_max(EXP_W));

  fp_class_t x_cls, y_cls;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) u_cls_x (
    .exp_in(Ex), .man_in(Mx), .cls(x_cls)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DAZ(DAZ)) u_cls_y (
    .exp_in(Ey), .man_in(My), .cls(y_cls)
  );

  fp_class_t x_d [LAT];
  fp_class_t y_d [LAT];
  fp_class_t x_pipe [LAT];
  fp_class_t y_pipe [LAT];
  logic      v_d [LAT];
  logic      v_pipe [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign x_d[gi] = x_cls;
        assign y_d[gi] = y_cls;
        assign v_d[gi] = in_valid;
      end else begin : g_tail
        assign x_d[gi] = x_pipe[gi-1];
        assign y_d[gi] = y_pipe[gi-1];
        assign v_d[gi] = v_pipe[gi-1];
      end
    end
  endgenerate

  fp_class_t xs, ys;
  logic      vs;
  assign xs = x_pipe[LAT-1];
  assign ys = y_pipe[LAT-1];
  assign vs = v_pipe[LAT-1];

  logic res_max;
  logic inv_next, ovf_next, unf_next, zero_next;

  // Every flag is gated by the stage valid so bubbles never raise anything.
  always_comb begin
    res_max   = (Ez == EXP_MAX) && (Mz == '0);
    inv_next  = vs & (xs.nan | ys.nan | (xs.zero & ys.inf) | (xs.inf & ys.zero));
    ovf_next  = vs & !inv_next & (xs.inf | ys.inf | res_max | ovf_case);
    zero_next = vs & !inv_next & (xs.zero | ys.zero);
    unf_next  = vs & !inv_next & !zero_next & !ovf_next & unf_case;
  end

  logic [3:0]       sticky_base, sticky_next;
  logic [CNT_W-1:0] cnt_base, cnt_next;

  // A clear in the same cycle as a result keeps that result's contribution.
  always_comb begin
    sticky_base = clr_sticky ? 4'b0 : sticky_flags;
    cnt_base    = clr_sticky ? '0 : exc_count;
    sticky_next = sticky_base;
    sticky_next[STK_INV]  = sticky_base[STK_INV]  | inv_next;
    sticky_next[STK_OVF]  = sticky_base[STK_OVF]  | ovf_next;
    sticky_next[STK_UNF]  = sticky_base[STK_UNF]  | unf_next;
    sticky_next[STK_ZERO] = sticky_base[STK_ZERO] | zero_next;
    cnt_next = cnt_base;
    if ((inv_next | ovf_next | unf_next) && (cnt_base != '1))
      cnt_next = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
        v_pipe[i] <= 1'b0;
      end
      out_valid      <= 1'b0;
      invalid_flag   <= 1'b0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      zero_flag      <= 1'b0;
      nan_flag       <= 1'b0;
      sticky_flags   <= 4'b0;
      exc_count      <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        x_pipe[i] <= x_d[i];
        y_pipe[i] <= y_d[i];
        v_pipe[i] <= v_d[i];
      end
      out_valid      <= vs;
      invalid_flag   <= inv_next;
      overflow_flag  <= ovf_next;
      underflow_flag <= unf_next;
      zero_flag      <= zero_next;
      nan_flag       <= inv_next;
      sticky_flags   <= sticky_next;
      exc_count      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fp_exc_unit.sv
// Bench for fp_exc_unit: default, DAZ=1 and CNT_W=2 instances share stimulus
// and are compared against a per-cycle reference model of the flag rules.
module tb_fp_exc_unit;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int LAT = 7;
  localparam int N   = 4096;
  localparam bit [EW-1:0] EMAX = 8'hFF;

  logic CLK = 1'b0;
  logic RST;
  logic in_valid = 1'b0;
  logic [EW-1:0] Ex = '0, Ey = '0, Ez = '0;
  logic [MW-1:0] Mx = '0, My = '0, Mz = '0;
  logic ovf_case = 1'b0, unf_case = 1'b0, clr_sticky = 1'b0;

  logic ov_a, inv_a, ovf_a, unf_a, zr_a, nan_a;
  logic ov_b, inv_b, ovf_b, unf_b, zr_b, nan_b;
  logic ov_c, inv_c, ovf_c, unf_c, zr_c, nan_c;
  logic [3:0]  sticky_a, sticky_b, sticky_c;
  logic [15:0] count_a, count_b;
  logic [1:0]  count_c;

  always #5 CLK = ~CLK;

  fp_exc_unit #(.LAT(LAT)) u_dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
    .Ez(Ez), .Mz(Mz), .ovf_case(ovf_case), .unf_case(unf_case), .clr_sticky(clr_sticky),
    .out_valid(ov_a), .invalid_flag(inv_a), .overflow_flag(ovf_a), .underflow_flag(unf_a),
    .zero_flag(zr_a), .nan_flag(nan_a), .sticky_flags(sticky_a), .exc_count(count_a)
  );
  fp_exc_unit #(.LAT(LAT), .DAZ(1)) u_dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
    .Ez(Ez), .Mz(Mz), .ovf_case(ovf_case), .unf_case(unf_case), .clr_sticky(clr_sticky),
    .out_valid(ov_b), .invalid_flag(inv_b), .overflow_flag(ovf_b), .underflow_flag(unf_b),
    .zero_flag(zr_b), .nan_flag(nan_b), .sticky_flags(sticky_b), .exc_count(count_b)
  );
  fp_exc_unit #(.LAT(LAT), .CNT_W(2)) u_dut_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My),
    .Ez(Ez), .Mz(Mz), .ovf_case(ovf_case), .unf_case(unf_case), .clr_sticky(clr_sticky),
    .out_valid(ov_c), .invalid_flag(inv_c), .overflow_flag(ovf_c), .underflow_flag(unf_c),
    .zero_flag(zr_c), .nan_flag(nan_c), .sticky_flags(sticky_c), .exc_count(count_c)
  );

  logic [25:0] obs_a, obs_b, exp_a, exp_b;
  logic [11:0] obs_c, exp_c;
  assign obs_a = {ov_a, inv_a, ovf_a, unf_a, zr_a, nan_a, sticky_a, count_a};
  assign obs_b = {ov_b, inv_b, ovf_b, unf_b, zr_b, nan_b, sticky_b, count_b};
  assign obs_c = {ov_c, inv_c, ovf_c, unf_c, zr_c, nan_c, sticky_c, count_c};

  // Issue record and result-side schedule, both indexed by cycle number.
  bit          r_iv [N];
  bit [EW-1:0] r_ex [N], r_ey [N], s_ez [N];
  bit [MW-1:0] r_mx [N], r_my [N], s_mz [N];
  bit          s_ovf [N], s_unf [N], s_clr [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit        ev;
  bit [4:0]  f_a, f_b;
  bit [3:0]  st_a, st_b;
  bit [15:0] cnt_a, cnt_b;
  bit [1:0]  cnt_c;

  // Returns {invalid, overflow, underflow, zero, nan} for one operation.
  function automatic bit [4:0] ref_flags(bit [EW-1:0] ex, bit [MW-1:0] mx, bit [EW-1:0] ey,
                                         bit [MW-1:0] my, bit [EW-1:0] ez, bit [MW-1:0] mz,
                                         bit ovf, bit unf, bit daz);
    bit x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, inv, ov, zr, un;
    x_nan  = (ex == EMAX) && (mx != 0);
    y_nan  = (ey == EMAX) && (my != 0);
    x_inf  = (ex == EMAX) && (mx == 0);
    y_inf  = (ey == EMAX) && (my == 0);
    x_zero = (ex == 0) && ((mx == 0) || daz);
    y_zero = (ey == 0) && ((my == 0) || daz);
    inv = x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero);
    ov  = !inv && (x_inf || y_inf || ((ez == EMAX) && (mz == 0)) || ovf);
    zr  = !inv && (x_zero || y_zero);
    un  = !inv && !zr && !ov && unf;
    return {inv, ov, un, zr, inv};
  endfunction

  function automatic bit [EW-1:0] rnd_exp();
    case ($urandom_range(3))
      0: return '0;
      1: return EMAX;
      default: return EW'($urandom_range(1, 254));
    endcase
  endfunction

  function automatic bit [MW-1:0] rnd_man();
    return ($urandom_range(1) == 0) ? '0 : MW'($urandom);
  endfunction

  task automatic model_clear();
    ev = 0; f_a = '0; f_b = '0;
    st_a = '0; st_b = '0; cnt_a = '0; cnt_b = '0; cnt_c = '0;
    exp_a = '0; exp_b = '0; exp_c = '0;
  endtask

  // Advances one clock and updates the model's expectation for the new cycle.
  task automatic step();
    int k;
    if (cyc >= N - LAT - 2) begin
      $display("FAIL cycle_budget: got cycle %0d required below %0d", cyc, N - LAT - 2);
      $fatal(1);
    end
    Ez = s_ez[cyc]; Mz = s_mz[cyc];
    ovf_case = s_ovf[cyc]; unf_case = s_unf[cyc]; clr_sticky = s_clr[cyc];
    r_iv[cyc] = in_valid && RST;
    r_ex[cyc] = Ex; r_mx[cyc] = Mx; r_ey[cyc] = Ey; r_my[cyc] = My;
    @(posedge CLK);
    #1;
    k = cyc - LAT;
    ev = 0; f_a = '0; f_b = '0;
    if (!RST) begin
      model_clear();
    end else begin
      if (k >= 0) ev = r_iv[k];
      if (ev) begin
        f_a = ref_flags(r_ex[k], r_mx[k], r_ey[k], r_my[k], Ez, Mz, ovf_case, unf_case, 1'b0);
        f_b = ref_flags(r_ex[k], r_mx[k], r_ey[k], r_my[k], Ez, Mz, ovf_case, unf_case, 1'b1);
      end
      if (clr_sticky) begin
        st_a = '0; st_b = '0; cnt_a = '0; cnt_b = '0; cnt_c = '0;
      end
      st_a |= f_a[4:1];
      st_b |= f_b[4:1];
      if (|f_a[4:2]) begin
        if (cnt_a != 16'hFFFF) cnt_a++;
        if (cnt_c != 2'b11) cnt_c++;
      end
      if ((|f_b[4:2]) && (cnt_b != 16'hFFFF)) cnt_b++;
    end
    cyc++;
    exp_a = {ev, f_a, st_a, cnt_a};
    exp_b = {ev, f_b, st_b, cnt_b};
    exp_c = {ev, f_a, st_a, cnt_c};
    if (ev)
      $display("op issued@%0d done@%0d: flags=%b sticky=%b count=%0d | daz flags=%b | cnt2=%0d",
               k, cyc, f_a, st_a, cnt_a, f_b, cnt_c);
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    for (int k = ((cyc - LAT - 1) < 0 ? 0 : cyc - LAT - 1); k <= cyc; k++) r_iv[k] = 0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    apply_reset();
    checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL reset_a: got %h required %h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL reset_b: got %h required %h", obs_b, exp_b); end
    checks++; if (obs_c !== exp_c) begin errors++; $display("FAIL reset_c: got %h required %h", obs_c, exp_c); end
    in_valid = 1'b1; Ex = EMAX; Mx = 23'd1;
    repeat (2) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL reset_hold_a: got %h required %h", obs_a, exp_a); end
    end
    in_valid = 1'b0;
    RST = 1'b1;
  endtask

  task automatic test_special();
    bit [EW-1:0] tex [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'h00};
    bit [MW-1:0] tmx [6] = '{23'd0, 23'd1, 23'd1, 23'd1, 23'd0, 23'd0};
    bit [EW-1:0] tey [6] = '{8'h00, 8'h7F, 8'hFF, 8'h7F, 8'h81, 8'hFF};
    bit [MW-1:0] tmy [6] = '{23'd0, 23'd0, 23'd0, 23'd0, 23'h400000, 23'd0};
    for (int i = 0; i < 6; i++) begin
      Ex = tex[i]; Mx = tmx[i]; Ey = tey[i]; My = tmy[i]; in_valid = 1'b1;
      for (int j = 0; j <= LAT; j++) begin
        step();
        in_valid = 1'b0;
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL special%0d_a: got %h required %h", i, obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL special%0d_b: got %h required %h", i, obs_b, exp_b); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      Ex = 8'h7F; Mx = rnd_man(); Ey = 8'h80; My = rnd_man(); in_valid = 1'b1;
      s_ovf[cyc + LAT] = k[0];
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_issue_a: got %h required %h", obs_a, exp_a); end
    end
    in_valid = 1'b0;
    repeat (LAT + 1) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_a: got %h required %h", obs_a, exp_a); end
      checks++; if (obs_c !== exp_c) begin errors++; $display("FAIL b2b_c: got %h required %h", obs_c, exp_c); end
    end
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      Ex = EMAX; Mx = '0; Ey = '0; My = '0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    apply_reset();
    checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL inflight_rst_a: got %h required %h", obs_a, exp_a); end
    step();
    RST = 1'b1;
    repeat (LAT + 3) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL inflight_drop_a: got %h required %h", obs_a, exp_a); end
    end
    Ex = 8'h00; Mx = '0; Ey = 8'h90; My = '0; in_valid = 1'b1;
    for (int j = 0; j <= LAT; j++) begin
      step();
      in_valid = 1'b0;
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL first_after_rst_a: got %h required %h", obs_a, exp_a); end
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 2; k++) begin
      Ex = EMAX; Mx = '0; Ey = '0; My = '0; in_valid = 1'b1;
      step();
    end
    Ex = EMAX; Mx = '0; Ey = 8'h40; My = '0; in_valid = 1'b1;
    s_clr[cyc + LAT] = 1'b1;
    step();
    in_valid = 1'b0;
    s_clr[cyc + LAT + 2] = 1'b1;
    repeat (LAT + 4) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL clear_a: got %h required %h", obs_a, exp_a); end
      checks++; if (obs_c !== exp_c) begin errors++; $display("FAIL clear_c: got %h required %h", obs_c, exp_c); end
    end
  endtask

  task automatic test_saturation();
    s_clr[cyc] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      Ex = EMAX; Mx = MW'($urandom_range(1, 1000)); Ey = 8'h7F; My = '0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (LAT + 1) begin
      step();
      checks++; if (obs_c !== exp_c) begin errors++; $display("FAIL saturate_c: got %h required %h", obs_c, exp_c); end
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL saturate_a: got %h required %h", obs_a, exp_a); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      in_valid = ($urandom_range(3) != 0);
      Ex = rnd_exp(); Mx = rnd_man(); Ey = rnd_exp(); My = rnd_man();
      s_ez[cyc]  = ($urandom_range(7) == 0) ? EMAX : EW'($urandom_range(0, 254));
      s_mz[cyc]  = rnd_man();
      s_ovf[cyc] = ($urandom_range(3) == 0);
      s_unf[cyc] = ($urandom_range(2) == 0);
      s_clr[cyc] = ($urandom_range(30) == 0);
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL random_a: got %h required %h", obs_a, exp_a); end
      checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL random_b: got %h required %h", obs_b, exp_b); end
      checks++; if (obs_c !== exp_c) begin errors++; $display("FAIL random_c: got %h required %h", obs_c, exp_c); end
    end
    in_valid = 1'b0;
    repeat (LAT + 1) begin
      step();
      checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL random_flush_a: got %h required %h", obs_a, exp_a); end
    end
  endtask

  initial begin
    test_reset();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    test_clear();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_exc_unit.md
FP_EXC_UNIT -- requirements
Module: fp_exc_unit

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width (no hidden bit).
REQ-003 Parameter LAT, default 7, cycles from operand issue to the aligned datapath result; minimum 1.
REQ-004 Parameter DAZ, default 0; when 1, subnormal operands (exp=0, man!=0) SHALL be classified as zero.
REQ-005 Parameter CNT_W, default 16, exception counter width.
REQ-006 CLK  in  1  clock, rising edge.
REQ-007 RST  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  1  operand pair valid this cycle.
REQ-009 Ex, Ey  in  EXP_W  operand exponents.
REQ-010 Mx, My  in  MAN_W  operand mantissas.
REQ-011 Ez  in  EXP_W  datapath result exponent, aligned to issue cycle + LAT.
REQ-012 Mz  in  MAN_W  datapath result mantissa, same alignment.
REQ-013 ovf_case, unf_case  in  1 each  datapath overflow/underflow indications, same alignment.
REQ-014 clr_sticky  in  1  synchronous clear of sticky flags and counter.
REQ-015 out_valid  out  1  flag outputs valid.
REQ-016 invalid_flag, overflow_flag, underflow_flag, zero_flag, nan_flag  out  1 each  per-operation flags.
REQ-017 sticky_flags  out  4  accumulated {invalid, overflow, underflow, zero}, MSB first.
REQ-018 exc_count  out  CNT_W  saturating count of operations with invalid, overflow or underflow set.

Function
REQ-019 Each operand SHALL be classified at issue into {zero, sub, inf, nan}: zero=exp0&man0, sub=exp0&man!=0, inf=expmax&man0, nan=expmax&man!=0.
REQ-020 Only the class bits and in_valid SHALL be delayed through a LAT-stage pipeline; raw operands SHALL NOT be piped.
REQ-021 Ez, Mz, ovf_case and unf_case SHALL be sampled once at the cycle the class stage LAT-1 output is presented, i.e. issue + LAT.
REQ-022 Flags SHALL be registered and presented at issue + LAT + 1, with out_valid=1; total latency LAT+1.
REQ-023 invalid = x_nan | y_nan | (x_zero & y_inf) | (x_inf & y_zero).
REQ-024 nan_flag = invalid.
REQ-025 overflow = !invalid & ((x_inf | y_inf) | (Ez==expmax & Mz==0) | ovf_case).
REQ-026 zero = !invalid & (x_zero | y_zero).
REQ-027 underflow = !invalid & !zero & !overflow & unf_case.
REQ-028 With DAZ=1, sub SHALL be treated as zero in REQ-023..027; with DAZ=0, sub is finite non-zero.
REQ-029 When out_valid=0, all five per-op flags SHALL be 0; bubbles SHALL propagate without flags.
REQ-030 Back-to-back issue at one op per cycle SHALL be supported with no stall.
REQ-031 sticky_flags SHALL OR in {invalid, overflow, underflow, zero} on every out_valid cycle.
REQ-032 exc_count SHALL increment by 1 on out_valid with (invalid|overflow|underflow), and SHALL saturate at all-ones.
REQ-033 On clr_sticky coincident with out_valid, the result SHALL be cleared state plus the current op's contribution (count=1 if exceptional).

Reset
REQ-034 RST low SHALL immediately clear pipeline valids, class stages, sampled result regs, all flags, out_valid, sticky_flags and exc_count to 0.
REQ-035 Ops in flight at reset SHALL be discarded; after release, the first out_valid SHALL occur LAT+1 cycles after the first post-reset in_valid.

Structure
REQ-036 Package fp_exc_pkg SHALL hold the class struct typedef (zero, sub, inf, nan), the sticky bit index constants, and expmax as a function of EXP_W.
REQ-037 Sub-module fp_classify (combinational, parametrised EXP_W/MAN_W/DAZ) SHALL be instantiated once per operand.

Verification (defaults, issue at cycle t)
REQ-038 x=inf (Ex=FF, Mx=0), y=0 (Ey=0, My=0) -> at t+8: invalid=1, nan=1, overflow=0, zero=0; sticky=1000; count=1.
REQ-039 x=NaN (Ex=FF, Mx=1), y=1.0 -> at t+8: invalid=1; the same op with y=inf gives invalid=1, overflow=0.
REQ-040 x=sub (Ex=0, Mx=1), y=1.0: DAZ=0 -> zero=0; DAZ=1 -> zero=1; count unchanged.
REQ-041 Eight back-to-back ops alternating normal/overflow (ovf_case=1 at t+7+2k) -> out_valid on 8 consecutive cycles, overflow alternating 0/1, count=4.
REQ-042 Issue 3 ops, then RST low at t+3 -> no out_valid, all outputs 0; clr_sticky with an exceptional out_valid -> sticky holds only the current bit, count=1.
REQ-043 With CNT_W=2, 5 exceptional ops -> exc_count=3.
